// File: rtl/mux_key_with_default_if.sv
// Bus bundle for the key-to-data lookup mux: table, key and default in; lookup results out.
// multi_hit exists only when MUXKEY_MULTI_HIT_EN is defined.
`timescale 1ns/1ps
interface mux_key_with_default_if #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
);
  logic [KEY_LEN-1:0]                   key;
  logic [DATA_LEN-1:0]                  default_out;
  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut;
  logic [DATA_LEN-1:0]                  out;
  logic                                 hit;
  logic [DATA_LEN-1:0]                  out_q;
  logic                                 hit_q;
`ifdef MUXKEY_MULTI_HIT_EN
  logic                                 multi_hit;
`endif

  // No valid/ready handshake: key/lut/default_out are sampled every cycle,
  // out/hit answer combinationally and out_q/hit_q follow one edge later.
  modport master (
    output key, default_out, lut,
`ifdef MUXKEY_MULTI_HIT_EN
    input  multi_hit,
`endif
    input  out, hit, out_q, hit_q
  );

  modport slave (
    input  key, default_out, lut,
`ifdef MUXKEY_MULTI_HIT_EN
    output multi_hit,
`endif
    output out, hit, out_q, hit_q
  );
endinterface

// File: rtl/mux_key_with_default.sv
// Priority key-to-data lookup mux with default, plus a registered copy of the result.
// Optional feature macro: MUXKEY_MULTI_HIT_EN (adds the multi_hit detector).
`timescale 1ns/1ps
module mux_key_with_default #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  mux_key_with_default_if.slave        bus
);
  localparam int P = KEY_LEN + DATA_LEN;

  logic [NR_KEY-1:0]   match;
  logic [DATA_LEN-1:0] out_d;
  logic                hit_d;
  logic [DATA_LEN-1:0] out_q;
  logic                hit_q;

  always_comb begin
    match = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      match[i] = (bus.lut[P*i+DATA_LEN +: KEY_LEN] == bus.key);
    end
  end

  // Walk from the top entry down so the lowest-index match is the last writer.
  always_comb begin
    out_d = bus.default_out;
    hit_d = 1'b0;
    for (int i = NR_KEY-1; i >= 0; i--) begin
      if (match[i]) begin
        out_d = bus.lut[P*i +: DATA_LEN];
        hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else begin
      out_q <= out_d;
      hit_q <= hit_d;
    end
  end

  assign bus.out   = out_d;
  assign bus.hit   = hit_d;
  assign bus.out_q = out_q;
  assign bus.hit_q = hit_q;

`ifdef MUXKEY_MULTI_HIT_EN
  logic multi_hit_d;
  logic multi_hit_q;
  logic seen;

  always_comb begin
    multi_hit_d = 1'b0;
    seen        = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (match[i]) begin
        if (seen) multi_hit_d = 1'b1;
        seen = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) multi_hit_q <= 1'b0;
    else     multi_hit_q <= multi_hit_d;
  end

  assign bus.multi_hit = multi_hit_d;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (multi_hit_d && !rst)
      $display("[%0t] mux_key_with_default warning: key %h matches several entries (prev cycle multi=%0b)",
               $time, bus.key, multi_hit_q);
  end
`endif
`endif
endmodule

// File: tb/tb_mux_key_with_default.sv
// Directed and model-checked bench for mux_key_with_default in two table geometries.
`timescale 1ns/1ps
module tb_mux_key_with_default;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Scoreboard of {hit,out} expected on out_q/hit_q one edge later.
  logic [4:0] exp_q[$];

  mux_key_with_default_if #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) if_a ();
  mux_key_with_default_if #(.NR_KEY(4), .KEY_LEN(7), .DATA_LEN(4)) if_b ();

  mux_key_with_default #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a.slave)
  );
  mux_key_with_default #(.NR_KEY(4), .KEY_LEN(7), .DATA_LEN(4)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ent(input logic [6:0] k, input logic [3:0] d);
    return {k, d};
  endfunction

  // Reference: first matching entry scanning upward, default otherwise.
  function automatic logic [4:0] model_b(input logic [43:0] lut, input logic [6:0] key,
                                         input logic [3:0] dflt);
    logic [4:0] r;
    logic       found;
    r     = {1'b0, dflt};
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && lut[11*i+4 +: 7] == key) begin
        r     = {1'b1, lut[11*i +: 4]};
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic int count_b(input logic [43:0] lut, input logic [6:0] key);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (lut[11*i+4 +: 7] == key) n++;
    return n;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    if_a.lut = 2'b01; if_a.key = 1'b0; if_a.default_out = 1'b0;
    if_b.lut = {ent(7'h6F, 4'h8), ent(7'h13, 4'h4), ent(7'h23, 4'h2), ent(7'h03, 4'h1)};
    if_b.key = 7'h03; if_b.default_out = 4'h0;
    @(posedge clk); #1;
    total++;
    if (if_a.out_q !== 1'b0 || if_a.hit_q !== 1'b0) begin
      bad++; $display("FAIL reset_a: out_q=%b hit_q=%b required 0 0", if_a.out_q, if_a.hit_q);
    end
    total++;
    if (if_b.out_q !== 4'h0 || if_b.hit_q !== 1'b0) begin
      bad++; $display("FAIL reset_b: out_q=%h hit_q=%b required 0 0", if_b.out_q, if_b.hit_q);
    end
    total++;
    if (if_a.out !== 1'b1 || if_a.hit !== 1'b1) begin
      bad++; $display("FAIL reset_comb_a: out=%b hit=%b required 1 1", if_a.out, if_a.hit);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    if_a.lut = 2'b01; if_a.key = 1'b0; if_a.default_out = 1'b0;
    #1;
    total++;
    if (if_a.out !== 1'b1 || if_a.hit !== 1'b1) begin
      bad++; $display("FAIL single_hit: out=%b hit=%b required 1 1", if_a.out, if_a.hit);
    end
    @(posedge clk); #1;
    total++;
    if (if_a.out_q !== 1'b1 || if_a.hit_q !== 1'b1) begin
      bad++; $display("FAIL single_reg: out_q=%b hit_q=%b required 1 1", if_a.out_q, if_a.hit_q);
    end
    @(negedge clk);
    if_a.key = 1'b1; if_a.default_out = 1'b0;
    #1;
    total++;
    if (if_a.out !== 1'b0 || if_a.hit !== 1'b0) begin
      bad++; $display("FAIL single_miss_d0: out=%b hit=%b required 0 0", if_a.out, if_a.hit);
    end
    if_a.default_out = 1'b1;
    #1;
    total++;
    if (if_a.out !== 1'b1 || if_a.hit !== 1'b0) begin
      bad++; $display("FAIL single_miss_d1: out=%b hit=%b required 1 0", if_a.out, if_a.hit);
    end
    @(posedge clk); #1;
    total++;
    if (if_a.out_q !== 1'b1 || if_a.hit_q !== 1'b0) begin
      bad++; $display("FAIL single_miss_reg: out_q=%b hit_q=%b required 1 0", if_a.out_q, if_a.hit_q);
    end
  endtask

  task automatic test_table();
    logic [6:0] keys [4] = '{7'h03, 7'h23, 7'h13, 7'h6F};
    logic [3:0] datas[4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    @(negedge clk);
    if_b.lut = {ent(7'h6F, 4'h8), ent(7'h13, 4'h4), ent(7'h23, 4'h2), ent(7'h03, 4'h1)};
    if_b.default_out = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if_b.key = keys[i];
      #1;
      total++;
      if (if_b.out !== datas[i] || if_b.hit !== 1'b1) begin
        bad++; $display("FAIL table_key%0d: out=%h hit=%b required %h 1", i, if_b.out, if_b.hit, datas[i]);
      end
    end
    if_b.key = 7'h37;
    #1;
    total++;
    if (if_b.out !== 4'hF || if_b.hit !== 1'b0) begin
      bad++; $display("FAIL table_miss: out=%h hit=%b required f 0", if_b.out, if_b.hit);
    end
    @(posedge clk); #1;
    total++;
    if (if_b.out_q !== 4'hF || if_b.hit_q !== 1'b0) begin
      bad++; $display("FAIL table_miss_reg: out_q=%h hit_q=%b required f 0", if_b.out_q, if_b.hit_q);
    end
  endtask

  task automatic test_duplicate();
    @(negedge clk);
    if_b.lut = {ent(7'h03, 4'hA), ent(7'h20, 4'h2), ent(7'h03, 4'h5), ent(7'h10, 4'h1)};
    if_b.default_out = 4'h0;
    if_b.key = 7'h03;
    #1;
    total++;
    if (if_b.out !== 4'h5 || if_b.hit !== 1'b1) begin
      bad++; $display("FAIL dup_priority: out=%h hit=%b required 5 1", if_b.out, if_b.hit);
    end
`ifdef MUXKEY_MULTI_HIT_EN
    total++;
    if (if_b.multi_hit !== 1'b1) begin
      bad++; $display("FAIL dup_multi_hit: multi_hit=%b required 1", if_b.multi_hit);
    end
`endif
    if_b.key = 7'h20;
    #1;
    total++;
    if (if_b.out !== 4'h2 || if_b.hit !== 1'b1) begin
      bad++; $display("FAIL dup_single: out=%h hit=%b required 2 1", if_b.out, if_b.hit);
    end
`ifdef MUXKEY_MULTI_HIT_EN
    total++;
    if (if_b.multi_hit !== 1'b0) begin
      bad++; $display("FAIL dup_single_multi: multi_hit=%b required 0", if_b.multi_hit);
    end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_b.lut = {ent(7'h6F, 4'h8), ent(7'h13, 4'h4), ent(7'h23, 4'h2), ent(7'h03, 4'h1)};
    if_b.key = 7'h13; if_b.default_out = 4'h0;
    @(posedge clk); #1;
    total++;
    if (if_b.out_q !== 4'h4 || if_b.hit_q !== 1'b1) begin
      bad++; $display("FAIL mid_pre: out_q=%h hit_q=%b required 4 1", if_b.out_q, if_b.hit_q);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (if_b.out_q !== 4'h0 || if_b.hit_q !== 1'b0) begin
      bad++; $display("FAIL mid_rst_reg: out_q=%h hit_q=%b required 0 0", if_b.out_q, if_b.hit_q);
    end
    total++;
    if (if_b.out !== 4'h4 || if_b.hit !== 1'b1) begin
      bad++; $display("FAIL mid_rst_comb: out=%h hit=%b required 4 1", if_b.out, if_b.hit);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (if_b.out_q !== 4'h4 || if_b.hit_q !== 1'b1) begin
      bad++; $display("FAIL mid_release: out_q=%h hit_q=%b required 4 1", if_b.out_q, if_b.hit_q);
    end
  endtask

  task automatic test_random(input int cycles);
    logic [43:0] lut;
    logic [6:0]  key;
    logic [3:0]  dflt;
    logic [4:0]  exp;
    logic [4:0]  old;
    exp_q.delete();
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        old = exp_q.pop_front();
        total++;
        if ({if_b.hit_q, if_b.out_q} !== old) begin
          bad++; $display("FAIL rand_reg cycle %0d: hit_q,out_q=%b,%h required %b,%h",
                          n, if_b.hit_q, if_b.out_q, old[4], old[3:0]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        lut[11*i+4 +: 7] = 7'($urandom_range(0, 7));
        lut[11*i +: 4]   = 4'($urandom_range(0, 15));
      end
      key  = 7'($urandom_range(0, 9));
      dflt = 4'($urandom_range(0, 15));
      if_b.lut = lut; if_b.key = key; if_b.default_out = dflt;
      exp = model_b(lut, key, dflt);
      #1;
      total++;
      if ({if_b.hit, if_b.out} !== exp) begin
        bad++; $display("FAIL rand_comb cycle %0d: hit,out=%b,%h required %b,%h key=%h lut=%h",
                        n, if_b.hit, if_b.out, exp[4], exp[3:0], key, lut);
      end
`ifdef MUXKEY_MULTI_HIT_EN
      total++;
      if (if_b.multi_hit !== (count_b(lut, key) > 1)) begin
        bad++; $display("FAIL rand_multi cycle %0d: multi_hit=%b", n, if_b.multi_hit);
      end
`endif
      exp_q.push_back(exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if_a.key = '0; if_a.default_out = '0; if_a.lut = '0;
    if_b.key = '0; if_b.default_out = '0; if_b.lut = '0;
    test_reset();
    test_single();
    test_table();
    test_duplicate();
    test_reset_mid();
    test_random(10000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
